dual_issue_scheduler: RTL and testbench

//  Pair-steering scheduler in front of the two decode lanes of the dual-issue RV32I core.
//  - Lane A: branch/ALU decode.
//  - Lane B: load/store/ALU decode.

---
 rtl/sched_pkg.sv | 30 +++
 rtl/instr_classifier.sv | 62 ++++++
 rtl/dual_issue_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and encodings for the dual-issue pair scheduler and its instruction classifier.
package sched_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {CLS_ALU, CLS_MEM, CLS_CTRL, CLS_OTHER} instr_cls_e;

  typedef enum logic {S_PAIR, S_HELD} sched_state_e;

  typedef struct packed {
    instr_cls_e cls;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
  } instr_info_t;

endpackage

// File: rtl/instr_classifier.sv
// Combinational decode of one RV32I instruction into its lane class and register usage.
module instr_classifier
  import sched_pkg::*;
(
  input  logic [31:0] instr,
  output instr_info_t info
);

  logic [6:0] opcode;
  assign opcode = instr[6:0];

  always_comb begin
    info           = '0;
    info.cls       = CLS_OTHER;
    info.rd        = instr[11:7];
    info.rs1       = instr[19:15];
    info.rs2       = instr[24:20];
    unique case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        info.cls       = CLS_ALU;
        info.writes_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        info.cls       = CLS_ALU;
        info.uses_rs1  = 1'b1;
        info.writes_rd = 1'b1;
      end
      OPC_OP: begin
        info.cls       = CLS_ALU;
        info.uses_rs1  = 1'b1;
        info.uses_rs2  = 1'b1;
        info.writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        info.cls       = CLS_MEM;
        info.uses_rs1  = 1'b1;
        info.writes_rd = 1'b1;
      end
      OPC_STORE: begin
        info.cls       = CLS_MEM;
        info.uses_rs1  = 1'b1;
        info.uses_rs2  = 1'b1;
      end
      OPC_JAL: begin
        info.cls       = CLS_CTRL;
        info.writes_rd = 1'b1;
      end
      OPC_JALR: begin
        info.cls       = CLS_CTRL;
        info.uses_rs1  = 1'b1;
        info.writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        info.cls       = CLS_CTRL;
        info.uses_rs1  = 1'b1;
        info.uses_rs2  = 1'b1;
      end
      default: info.cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Steers an in-order instruction pair onto decode lanes A/B, splitting pairs that cannot dual-issue.
// Optional SCHED_PERF_CNT_EN adds dual-issue and split event counters.
module dual_issue_scheduler
  import sched_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = sched_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr0_i,
  input  logic [31:0] instr1_i,
  input  logic [31:0] pc0_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        lane_a_valid_o,
  output logic [31:0] lane_a_instr_o,
  output logic [31:0] lane_a_pc_o,
  output logic        lane_b_valid_o,
  output logic [31:0] lane_b_instr_o,
  output logic [31:0] lane_b_pc_o,
  output logic        prio_o
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0] dual_cnt_o,
  output logic [31:0] split_cnt_o
`endif
);

  instr_info_t info0, info1;

  instr_classifier u_cls0 (.instr(instr0_i), .info(info0));
  instr_classifier u_cls1 (.instr(instr1_i), .info(info1));

  sched_state_e state_q, state_d;
  logic [31:0]  held_instr_q, held_instr_d;
  logic [31:0]  held_pc_q, held_pc_d;
  logic         held_mem_q, held_mem_d;

  logic        a_valid_d, b_valid_d, prio_d;
  logic [31:0] a_instr_d, a_pc_d, b_instr_d, b_pc_d;

  logic        fit, raw, waw, dual_ok, accept;
  logic [31:0] pc1;

  assign pc1        = pc0_i + 32'd4;
  assign in_ready_o = (state_q == S_PAIR) && !stall_i && !flush_i;
  assign accept     = in_ready_o && in_valid_i;

  // The older instruction must be ALU or MEM, and the younger must land on the other lane
  // under the fixed assignment (MEM first -> younger on A; ALU first -> younger on B).
  always_comb begin
    fit = 1'b0;
    unique case (info0.cls)
      CLS_MEM: fit = (info1.cls == CLS_ALU) || (info1.cls == CLS_CTRL);
      CLS_ALU: fit = (info1.cls == CLS_ALU) || (info1.cls == CLS_MEM);
      default: fit = 1'b0;
    endcase
  end

  assign raw = info0.writes_rd && (info0.rd != 5'd0) &&
               ((info1.uses_rs1 && (info1.rs1 == info0.rd)) ||
                (info1.uses_rs2 && (info1.rs2 == info0.rd)));
  assign waw = info0.writes_rd && info1.writes_rd && (info0.rd != 5'd0) &&
               (info1.rd == info0.rd);
  assign dual_ok = fit && !raw && !waw;

  logic unused_info0;
  assign unused_info0 = ^{info0.rs1, info0.rs2, info0.uses_rs1, info0.uses_rs2};

  always_comb begin
    state_d      = state_q;
    held_instr_d = held_instr_q;
    held_pc_d    = held_pc_q;
    held_mem_d   = held_mem_q;
    a_valid_d    = lane_a_valid_o;
    a_instr_d    = lane_a_instr_o;
    a_pc_d       = lane_a_pc_o;
    b_valid_d    = lane_b_valid_o;
    b_instr_d    = lane_b_instr_o;
    b_pc_d       = lane_b_pc_o;
    prio_d       = prio_o;

    if (flush_i) begin
      state_d      = S_PAIR;
      held_instr_d = '0;
      held_pc_d    = '0;
      held_mem_d   = 1'b0;
      a_valid_d    = 1'b0;
      a_instr_d    = NOP_INSTR;
      b_valid_d    = 1'b0;
      b_instr_d    = NOP_INSTR;
      prio_d       = 1'b0;
    end else if (!stall_i) begin
      a_valid_d = 1'b0;
      a_instr_d = NOP_INSTR;
      b_valid_d = 1'b0;
      b_instr_d = NOP_INSTR;
      prio_d    = 1'b0;
      unique case (state_q)
        S_PAIR: begin
          if (accept && dual_ok) begin
            a_valid_d = 1'b1;
            b_valid_d = 1'b1;
            if (info0.cls == CLS_MEM) begin
              b_instr_d = instr0_i;
              b_pc_d    = pc0_i;
              a_instr_d = instr1_i;
              a_pc_d    = pc1;
              prio_d    = 1'b1;
            end else begin
              a_instr_d = instr0_i;
              a_pc_d    = pc0_i;
              b_instr_d = instr1_i;
              b_pc_d    = pc1;
            end
          end else if (accept) begin
            if (info0.cls == CLS_MEM) begin
              b_valid_d = 1'b1;
              b_instr_d = instr0_i;
              b_pc_d    = pc0_i;
            end else begin
              a_valid_d = 1'b1;
              a_instr_d = instr0_i;
              a_pc_d    = pc0_i;
            end
            held_instr_d = instr1_i;
            held_pc_d    = pc1;
            held_mem_d   = (info1.cls == CLS_MEM);
            state_d      = S_HELD;
          end
        end
        S_HELD: begin
          if (held_mem_q) begin
            b_valid_d = 1'b1;
            b_instr_d = held_instr_q;
            b_pc_d    = held_pc_q;
          end else begin
            a_valid_d = 1'b1;
            a_instr_d = held_instr_q;
            a_pc_d    = held_pc_q;
          end
          state_d = S_PAIR;
        end
        default: state_d = S_PAIR;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q        <= S_PAIR;
      held_instr_q   <= '0;
      held_pc_q      <= '0;
      held_mem_q     <= 1'b0;
      lane_a_valid_o <= 1'b0;
      lane_a_instr_o <= NOP_INSTR;
      lane_a_pc_o    <= '0;
      lane_b_valid_o <= 1'b0;
      lane_b_instr_o <= NOP_INSTR;
      lane_b_pc_o    <= '0;
      prio_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      held_instr_q   <= held_instr_d;
      held_pc_q      <= held_pc_d;
      held_mem_q     <= held_mem_d;
      lane_a_valid_o <= a_valid_d;
      lane_a_instr_o <= a_instr_d;
      lane_a_pc_o    <= a_pc_d;
      lane_b_valid_o <= b_valid_d;
      lane_b_instr_o <= b_instr_d;
      lane_b_pc_o    <= b_pc_d;
      prio_o         <= prio_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Flush suppresses any issue that cycle, so only accepted pairs are counted.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      dual_cnt_o  <= '0;
      split_cnt_o <= '0;
    end else if (accept) begin
      if (dual_ok) dual_cnt_o  <= dual_cnt_o + 32'd1;
      else         split_cnt_o <= split_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed scoreboard bench for dual_issue_scheduler: stimulus pushes expectations, a monitor pops them.
module tb_dual_issue_scheduler;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW2  = 32'h0001a103;
  localparam logic [31:0] ADD  = 32'h00108133;
  localparam logic [31:0] LW1  = 32'h0001a083;
  localparam logic [31:0] SW   = 32'h0021a223;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] ADD5 = 32'h00500293;
  localparam logic [31:0] ADD7 = 32'h00700093;
  localparam logic [31:0] ZERO = 32'h00000000;

  logic        clk, rstn, in_valid, in_ready, stall, flush;
  logic [31:0] instr0, instr1, pc0;
  logic        a_valid, b_valid, prio;
  logic [31:0] a_instr, a_pc, b_instr, b_pc;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic        av;
    logic [31:0] ai;
    logic [31:0] apc;
    logic        bv;
    logic [31:0] bi;
    logic [31:0] bpc;
    logic        pr;
  } out_exp_t;

  typedef struct {
    int   due;
    logic rdy;
  } rdy_exp_t;

  out_exp_t outQ[$];
  rdy_exp_t rdyQ[$];

  dual_issue_scheduler dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .instr0_i      (instr0),
    .instr1_i      (instr1),
    .pc0_i         (pc0),
    .stall_i       (stall),
    .flush_i       (flush),
    .lane_a_valid_o(a_valid),
    .lane_a_instr_o(a_instr),
    .lane_a_pc_o   (a_pc),
    .lane_b_valid_o(b_valid),
    .lane_b_instr_o(b_instr),
    .lane_b_pc_o   (b_pc),
    .prio_o        (prio)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Inputs go on just after a rising edge; in_ready is due this cycle, lanes after the next edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] pc, input logic st, input logic fl, input logic er,
                               input logic av, input logic [31:0] ai, input logic [31:0] apc,
                               input logic bv, input logic [31:0] bi, input logic [31:0] bpc,
                               input logic pr);
    out_exp_t o;
    rdy_exp_t q;
    @(posedge clk);
    #1;
    rstn = r; in_valid = v; instr0 = i0; instr1 = i1; pc0 = pc; stall = st; flush = fl;
    q.due = cyc; q.rdy = er;
    rdyQ.push_back(q);
    o.due = cyc + 1; o.av = av; o.ai = ai; o.apc = apc; o.bv = bv; o.bi = bi; o.bpc = bpc; o.pr = pr;
    outQ.push_back(o);
  endtask

  initial begin : monitor
    rdy_exp_t q;
    out_exp_t o;
    forever begin
      @(negedge clk);
      while (rdyQ.size() > 0 && rdyQ[0].due <= cyc) begin
        q = rdyQ.pop_front();
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, q.rdy});
      end
      while (outQ.size() > 0 && outQ[0].due <= cyc) begin
        o = outQ.pop_front();
        checkOutput("lane_a_valid", {31'd0, a_valid}, {31'd0, o.av});
        checkOutput("lane_a_instr", a_instr, o.ai);
        checkOutput("lane_a_pc", a_pc, o.apc);
        checkOutput("lane_b_valid", {31'd0, b_valid}, {31'd0, o.bv});
        checkOutput("lane_b_instr", b_instr, o.bi);
        checkOutput("lane_b_pc", b_pc, o.bpc);
        checkOutput("prio", {31'd0, prio}, {31'd0, o.pr});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    rstn = 1'b0; in_valid = 1'b0; instr0 = '0; instr1 = '0; pc0 = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    // reset, then idle
    applyStimulus(0, 0, ZERO, ZERO, 0, 0, 0, 1, 0, NOP, 0, 0, NOP, 0, 0);
    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, 1, 0, NOP, 0, 0, NOP, 0, 0);
    // ALU + MEM dual issue
    applyStimulus(1, 1, ADDI, LW2, 32'h100, 0, 0, 1, 1, ADDI, 32'h100, 1, LW2, 32'h104, 0);
    // RAW split; offered pair during held cycle is ignored
    applyStimulus(1, 1, ADDI, ADD, 32'h200, 0, 0, 1, 1, ADDI, 32'h200, 0, NOP, 32'h104, 0);
    applyStimulus(1, 1, LW1, ADD5, 32'h280, 0, 0, 0, 1, ADD, 32'h204, 0, NOP, 32'h104, 0);
    // MEM + MEM split on lane B
    applyStimulus(1, 1, LW1, SW, 32'h300, 0, 0, 1, 0, NOP, 32'h204, 1, LW1, 32'h300, 0);
    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, 0, 0, NOP, 32'h204, 1, SW, 32'h304, 0);
    // CTRL first always splits
    applyStimulus(1, 1, BEQ, ADDI, 32'h400, 0, 0, 1, 1, BEQ, 32'h400, 0, NOP, 32'h304, 0);
    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, 0, 1, ADDI, 32'h404, 0, NOP, 32'h304, 0);
    // flush while held drops the held instruction
    applyStimulus(1, 1, ADDI, ADD, 32'h500, 0, 0, 1, 1, ADDI, 32'h500, 0, NOP, 32'h304, 0);
    applyStimulus(1, 1, ADDI, LW2, 32'h580, 0, 1, 0, 0, NOP, 32'h500, 0, NOP, 32'h304, 0);
    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, 1, 0, NOP, 32'h500, 0, NOP, 32'h304, 0);
    // stall for three cycles after a dual issue
    applyStimulus(1, 1, ADDI, LW2, 32'h600, 0, 0, 1, 1, ADDI, 32'h600, 1, LW2, 32'h604, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, LW1, ADD5, 32'h680, 1, 0, 0, 1, ADDI, 32'h600, 1, LW2, 32'h604, 0);
    // MEM first dual issue swaps lanes and raises prio
    applyStimulus(1, 1, LW1, ADD5, 32'h700, 0, 0, 1, 1, ADD5, 32'h704, 1, LW1, 32'h700, 1);
    // pc wrap
    applyStimulus(1, 1, ADDI, LW2, 32'hFFFFFFFC, 0, 0, 1, 1, ADDI, 32'hFFFFFFFC, 1, LW2, 32'h0, 0);
    // WAW split
    applyStimulus(1, 1, ADDI, ADD7, 32'h800, 0, 0, 1, 1, ADDI, 32'h800, 0, NOP, 32'h0, 0);
    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, 0, 1, ADD7, 32'h804, 0, NOP, 32'h0, 0);
    // OTHER (all-zero opcode) single issue on lane A
    applyStimulus(1, 1, ZERO, ADDI, 32'hA00, 0, 0, 1, 1, ZERO, 32'hA00, 0, NOP, 32'h0, 0);
    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, 0, 1, ADDI, 32'hA04, 0, NOP, 32'h0, 0);
    // reset while held, with stall and flush asserted
    applyStimulus(1, 1, ADDI, ADD, 32'h900, 0, 0, 1, 1, ADDI, 32'h900, 0, NOP, 32'h0, 0);
    applyStimulus(0, 0, ZERO, ZERO, 0, 1, 1, 0, 0, NOP, 0, 0, NOP, 0, 0);
    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, 1, 0, NOP, 0, 0, NOP, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (outQ.size() != 0 || rdyQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d pending required=0", outQ.size() + rdyQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
